// File: rtl/pes_pkg.sv
// pes_pkg: definitions shared by the pes serial-link blocks.
//   pes_state_t  - 2-bit FSM state encoding of the pattern transmitter
//   PES_DEF_PAT  - default 4-bit pattern that the pes_sdw detector looks for
package pes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10,
        ST_DONE  = 2'b11
    } pes_state_t;

    localparam logic [3:0] PES_DEF_PAT = 4'b1010;

endpackage

// File: rtl/pes_piso.sv
// pes_piso: PAT_W-bit parallel-in / serial-out shift register, MSB first.
// Ports:
//   clk    in   rising-edge clock
//   load   in   load din into the register (has priority over shift)
//   shift  in   shift left by one, zero fill
//   din    in   PAT_W parallel word
//   msb    out  current most significant bit
// The register holds data only; the owner qualifies msb with its own state,
// so it carries no reset.
module pes_piso #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] din,
    output logic             msb
);

    logic [PAT_W-1:0] shreg;

    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= din;
        end else if (shift) begin
            shreg <= {shreg[PAT_W-2:0], 1'b0};
        end
    end

    assign msb = shreg[PAT_W-1];

endmodule

// File: rtl/pes_seq_gen.sv
// pes_seq_gen: serial bit-pattern transmitter feeding the pes_sdw detector.
// On an accepted start it sends a captured PAT_W-bit pattern MSB first on
// dout, max(repeat_cnt,1) times, with gap_len zero cycles between repeats.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   start       in   burst request, sampled in IDLE only
//   abort       in   synchronous abort to IDLE without a done pulse
//   pattern     in   PAT_W bits to send, captured on start
//   repeat_cnt  in   number of repeats (0 behaves as 1), captured on start
//   gap_len     in   idle cycles between repeats, captured on start
//   dout        out  serial data
//   dout_valid  out  dout carries a pattern bit
//   busy        out  burst in progress (SHIFT or GAP)
//   done        out  one-cycle pulse after the last bit of the last repeat
module pes_seq_gen
    import pes_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [CNT_W-1:0] gap_len,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W - 1);

    pes_state_t       state;
    logic [BW-1:0]    bitcnt;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] gl;
    logic [CNT_W-1:0] gapcnt;
    logic [PAT_W-1:0] pat_cap;

    logic             start_ok;
    logic             last_bit;
    logic             piso_load;
    logic             piso_shift;
    logic [PAT_W-1:0] piso_din;
    logic             piso_msb;

    assign start_ok = (state == ST_IDLE) && start && !abort;
    assign last_bit = (bitcnt == LAST_BIT);

    // The shift register is reloaded on start, on a back-to-back repeat and
    // at the end of a gap; everything but the start reload uses the captured
    // copy so input changes mid-burst have no effect.
    assign piso_load  = start_ok
                      || ((state == ST_SHIFT) && last_bit && (rem > CNT_W'(1)) && (gl == '0))
                      || ((state == ST_GAP) && (gapcnt <= CNT_W'(1)));
    assign piso_din   = (state == ST_IDLE) ? pattern : pat_cap;
    assign piso_shift = (state == ST_SHIFT);

    pes_piso #(
        .PAT_W (PAT_W)
    ) u_piso (
        .clk   (clk),
        .load  (piso_load),
        .shift (piso_shift),
        .din   (piso_din),
        .msb   (piso_msb)
    );

    always_ff @(posedge clk) begin
        if (start_ok) begin
            pat_cap <= pattern;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            bitcnt <= '0;
            rem    <= '0;
            gl     <= '0;
            gapcnt <= '0;
        end else if (abort) begin
            state  <= ST_IDLE;
            bitcnt <= '0;
            gapcnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rem    <= (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
                        gl     <= gap_len;
                        bitcnt <= '0;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (last_bit) begin
                        bitcnt <= '0;
                        if (rem <= CNT_W'(1)) begin
                            state <= ST_DONE;
                        end else begin
                            rem <= rem - CNT_W'(1);
                            if (gl != '0) begin
                                gapcnt <= gl;
                                state  <= ST_GAP;
                            end
                        end
                    end else begin
                        bitcnt <= bitcnt + BW'(1);
                    end
                end
                ST_GAP: begin
                    if (gapcnt <= CNT_W'(1)) begin
                        gapcnt <= '0;
                        bitcnt <= '0;
                        state  <= ST_SHIFT;
                    end else begin
                        gapcnt <= gapcnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state and the shift register only.
    assign dout       = (state == ST_SHIFT) && piso_msb;
    assign dout_valid = (state == ST_SHIFT);
    assign busy       = (state == ST_SHIFT) || (state == ST_GAP);
    assign done       = (state == ST_DONE);

endmodule
